// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module  : ps2_pkg
//  Purpose : Shared frame-state encoding, PS/2 prefix and key codes, and
//            keyboard_data bit positions for the PS/2 keyboard decoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    localparam int KD_EXT     = 8;
    localparam int KD_BRK     = 9;
    localparam int KD_UP      = 10;
    localparam int KD_DOWN    = 11;
    localparam int KD_LEFT    = 12;
    localparam int KD_RIGHT   = 13;
    localparam int KD_SPACE   = 14;
    localparam int KD_ENTER   = 15;
    localparam int KD_CNT_LSB = 16;
    localparam int KD_CNT_MSB = 23;
    localparam int KD_USED    = 24;

    // Held-bit position for a (ext, code) pair; 0 means the key is not tracked.
    function automatic logic [4:0] held_pos(input logic ext, input logic [7:0] code);
        logic [4:0] pos;
        pos = 5'd0;
        if (ext) begin
            case (code)
                KEY_UP:    pos = 5'(KD_UP);
                KEY_DOWN:  pos = 5'(KD_DOWN);
                KEY_LEFT:  pos = 5'(KD_LEFT);
                KEY_RIGHT: pos = 5'(KD_RIGHT);
                default:   pos = 5'd0;
            endcase
        end else begin
            case (code)
                KEY_SPACE: pos = 5'(KD_SPACE);
                KEY_ENTER: pos = 5'(KD_ENTER);
                default:   pos = 5'd0;
            endcase
        end
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keyboard_decoder_if.sv
// ============================================================================
//  Module  : ps2_keyboard_decoder_if
//  Purpose : PS/2 pins and decoded status outputs of the keyboard decoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_keyboard_decoder_if #(
    parameter int bus = 32
);
    logic           ps2_clk;
    logic           ps2_data;
    logic [bus-1:0] keyboard_data;
    logic           key_valid;
    logic           frame_error;

    modport master (
        output ps2_clk, ps2_data,
        input  keyboard_data, key_valid, frame_error
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keyboard_data, key_valid, frame_error
    );
endinterface

`default_nettype wire

// File: rtl/ps2_edge_filter.sv
// ============================================================================
//  Module  : ps2_edge_filter
//  Purpose : Synchronizes ps2_clk/ps2_data, debounces ps2_clk and emits a
//            one-cycle pulse on each falling edge of the filtered clock.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_edge_filter #(
    parameter int FILTER = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic ps2_clk_i,
    input  wire logic ps2_data_i,
    output logic      fall_o,
    output logic      data_s_o
);
    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;
    logic          fall_q;

    // Filter and sync flops reset high so an idle bus produces no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER - 1)) begin
                filt_q <= clk_sync_q[1];
                cnt_q  <= '0;
                fall_q <= ~clk_sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign fall_o   = fall_q;
    assign data_s_o = data_sync_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_decoder.sv
// ============================================================================
//  Module  : ps2_keyboard_decoder
//  Purpose : PS/2 frame receiver with prefix tracking, held-key bitmap and
//            event counter, packed into the processor's keyboard_data word.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_decoder
    import ps2_pkg::*;
#(
    parameter int bus     = 32,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 5000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    ps2_keyboard_decoder_if.slave   kbd
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic             w_fall;
    logic             w_data;
    logic             w_accept;
    logic [4:0]       w_pos;

    logic [1:0]       state_q,  state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q,  shift_d;
    logic             par_q,    par_d;
    logic [WDW-1:0]   wd_q,     wd_d;
    logic             ext_q,    ext_d;
    logic             brk_q,    brk_d;
    logic [KD_USED-1:0] kd_q,   kd_d;
    logic             kv_q,     kv_d;
    logic             fe_q,     fe_d;

    ps2_edge_filter #(.FILTER(FILTER)) u_edge (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (kbd.ps2_clk),
        .ps2_data_i (kbd.ps2_data),
        .fall_o     (w_fall),
        .data_s_o   (w_data)
    );

    assign w_pos = held_pos(ext_q, shift_q);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        kd_d     = kd_q;
        kv_d     = 1'b0;
        fe_d     = 1'b0;
        w_accept = 1'b0;
        wd_d     = (state_q != ST_IDLE) ? wd_q + 1'b1 : '0;

        if (w_fall) begin
            wd_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!w_data) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {w_data, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = w_data;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (w_data && (^{shift_q, par_q})) begin
                        w_accept = 1'b1;
                    end else begin
                        fe_d  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q != ST_IDLE) && (wd_q == WDW'(TIMEOUT))) begin
            state_d = ST_IDLE;
            wd_d    = '0;
            fe_d    = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end

        // Prefix bytes only arm flags; everything else is a reportable scan code.
        if (w_accept) begin
            if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                kd_d[7:0]    = shift_q;
                kd_d[KD_EXT] = ext_q;
                kd_d[KD_BRK] = brk_q;
                for (int i = KD_UP; i <= KD_ENTER; i++) begin
                    if (w_pos == 5'(i)) kd_d[i] = ~brk_q;
                end
                kd_d[KD_CNT_MSB:KD_CNT_LSB] = kd_q[KD_CNT_MSB:KD_CNT_LSB] + 1'b1;
                kv_d  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
            par_q    <= 1'b0;
            wd_q     <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            kd_q     <= '0;
            kv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wd_q     <= wd_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            kd_q     <= kd_d;
            kv_q     <= kv_d;
            fe_q     <= fe_d;
        end
    end

    assign kbd.keyboard_data = bus'(kd_q);
    assign kbd.key_valid     = kv_q;
    assign kbd.frame_error   = fe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_decoder.sv
// ============================================================================
//  Module  : tb_ps2_keyboard_decoder
//  Purpose : Directed self-checking bench for ps2_keyboard_decoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_keyboard_decoder;
    localparam int H   = 8;
    localparam int FLT = 4;
    localparam int TO  = 200;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   kv_cnt   = 0;
    int   fe_cnt   = 0;
    int   both_cnt = 0;

    always #5 clk = ~clk;

    ps2_keyboard_decoder_if #(.bus(32)) kbd ();

    ps2_keyboard_decoder #(.bus(32), .FILTER(FLT), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .kbd   (kbd)
    );

    always @(negedge clk) begin
        if (kbd.key_valid)   kv_cnt++;
        if (kbd.frame_error) fe_cnt++;
        if (kbd.key_valid && kbd.frame_error) both_cnt++;
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        kbd.ps2_data = b;
        repeat (1) @(negedge clk);
        kbd.ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        kbd.ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~^b : ^b);
        ps2_bit(stop);
        kbd.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        kbd.ps2_clk  = 1'b1;
        kbd.ps2_data = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (kbd.keyboard_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_kd got=%h exp=%h", kbd.keyboard_data, 32'h0);
        end
        checks++;
        if (kbd.key_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_kv got=%b exp=0", kbd.key_valid);
        end
        checks++;
        if (kbd.frame_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_fe got=%b exp=0", kbd.frame_error);
        end
    endtask

    task automatic test_basic();
        int k0;
        k0 = kv_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (kv_cnt - k0 !== 1) begin
            failures++;
            $display("FAIL basic_kv_pulses got=%0d exp=1", kv_cnt - k0);
        end
        checks++;
        if (kbd.keyboard_data !== 32'h0001_001C) begin
            failures++;
            $display("FAIL basic_kd got=%h exp=%h", kbd.keyboard_data, 32'h0001_001C);
        end
    endtask

    task automatic test_ext();
        int k0;
        do_reset();
        k0 = kv_cnt;
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0001_0575) begin
            failures++;
            $display("FAIL ext_make_up got=%h exp=%h", kbd.keyboard_data, 32'h0001_0575);
        end
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0002_0375) begin
            failures++;
            $display("FAIL ext_break_up got=%h exp=%h", kbd.keyboard_data, 32'h0002_0375);
        end
        checks++;
        if (kv_cnt - k0 !== 2) begin
            failures++;
            $display("FAIL ext_kv_pulses got=%0d exp=2", kv_cnt - k0);
        end
    endtask

    task automatic test_parity();
        int k0, f0;
        k0 = kv_cnt;
        f0 = fe_cnt;
        send_frame(8'h29, 1'b0, 1'b1);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL parity_fe got=%0d exp=1", fe_cnt - f0);
        end
        checks++;
        if (kv_cnt - k0 !== 0) begin
            failures++;
            $display("FAIL parity_kv got=%0d exp=0", kv_cnt - k0);
        end
        checks++;
        if (kbd.keyboard_data !== 32'h0002_0375) begin
            failures++;
            $display("FAIL parity_kd got=%h exp=%h", kbd.keyboard_data, 32'h0002_0375);
        end
    endtask

    task automatic test_reject_clears_brk();
        int f0;
        f0 = fe_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, 1'b0);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL stopbit_fe got=%0d exp=1", fe_cnt - f0);
        end
        send_frame(8'h29, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0003_4029) begin
            failures++;
            $display("FAIL brk_cleared_kd got=%h exp=%h", kbd.keyboard_data, 32'h0003_4029);
        end
    endtask

    task automatic test_timeout();
        int f0;
        f0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 40) @(negedge clk);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL timeout_fe got=%0d exp=1", fe_cnt - f0);
        end
        checks++;
        if (kbd.keyboard_data !== 32'h0003_4029) begin
            failures++;
            $display("FAIL timeout_kd got=%h exp=%h", kbd.keyboard_data, 32'h0003_4029);
        end
        send_frame(8'h5A, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0004_C05A) begin
            failures++;
            $display("FAIL after_timeout_kd got=%h exp=%h", kbd.keyboard_data, 32'h0004_C05A);
        end
    endtask

    task automatic test_glitch();
        int k0, f0;
        k0 = kv_cnt;
        f0 = fe_cnt;
        kbd.ps2_data = 1'b0;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            kbd.ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            kbd.ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        kbd.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0005_C01C) begin
            failures++;
            $display("FAIL glitch_kd got=%h exp=%h", kbd.keyboard_data, 32'h0005_C01C);
        end
        checks++;
        if ((kv_cnt - k0 !== 1) || (fe_cnt - f0 !== 0)) begin
            failures++;
            $display("FAIL glitch_pulses kv=%0d fe=%0d exp kv=1 fe=0", kv_cnt - k0, fe_cnt - f0);
        end
    endtask

    task automatic test_boundary();
        send_frame(8'h5A, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0006_C05A) begin
            failures++;
            $display("FAIL repeat_make_kd got=%h exp=%h", kbd.keyboard_data, 32'h0006_C05A);
        end
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h72, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0007_C372) begin
            failures++;
            $display("FAIL break_unheld_kd got=%h exp=%h", kbd.keyboard_data, 32'h0007_C372);
        end
    endtask

    task automatic test_wrap();
        int k0;
        k0 = kv_cnt;
        for (int n = 0; n < 256; n++) send_frame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (kbd.keyboard_data !== 32'h0007_C01C) begin
            failures++;
            $display("FAIL wrap_kd got=%h exp=%h", kbd.keyboard_data, 32'h0007_C01C);
        end
        checks++;
        if (kv_cnt - k0 !== 256) begin
            failures++;
            $display("FAIL wrap_kv_pulses got=%0d exp=256", kv_cnt - k0);
        end
    endtask

    initial begin
        kbd.ps2_clk  = 1'b1;
        kbd.ps2_data = 1'b1;
        test_reset();
        test_basic();
        test_ext();
        test_parity();
        test_reject_clears_brk();
        test_timeout();
        test_glitch();
        test_boundary();
        test_wrap();
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL kv_fe_overlap got=%0d exp=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
